// File: rtl/ad1_s00_axi_regs.sv
// AXI4-Lite slave with four 32-bit software registers for the ad1 IP.
// Optional macro AD1_ADDR_DECODE_ERR_EN: out-of-range addresses return SLVERR.
module ad1_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_NUM_REGS         = 4
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] slv_regs
);

  localparam int unsigned STRB_W      = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [C_NUM_REGS];

  logic                          aw_full, w_full;
  logic [1:0]                    aw_idx;
  logic                          aw_err;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]             w_strb;

  logic                          aw_ready_q, w_ready_q, bvalid_q;
  logic [1:0]                    bresp_q;
  logic                          ar_ready_q, rvalid_q;
  logic [1:0]                    rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic aw_full_n, w_full_n, bvalid_n;
  logic aw_oor, ar_oor;

`ifdef AD1_ADDR_DECODE_ERR_EN
  assign aw_oor = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4];
  assign ar_oor = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // Protection bits and unused address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  always_comb begin
    aw_hs  = S_AXI_AWVALID && aw_ready_q;
    w_hs   = S_AXI_WVALID && w_ready_q;
    b_hs   = bvalid_q && S_AXI_BREADY;
    ar_hs  = S_AXI_ARVALID && ar_ready_q;
    r_hs   = rvalid_q && S_AXI_RREADY;
    commit = aw_full && w_full && !bvalid_q;

    aw_full_n = aw_full;
    if (aw_hs)  aw_full_n = 1'b1;
    if (commit) aw_full_n = 1'b0;

    w_full_n = w_full;
    if (w_hs)   w_full_n = 1'b1;
    if (commit) w_full_n = 1'b0;

    bvalid_n = bvalid_q;
    if (b_hs)   bvalid_n = 1'b0;
    if (commit) bvalid_n = 1'b1;
  end

  // Ready flags are registered from next-state so they drop on the capturing edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full    <= 1'b0;
      w_full     <= 1'b0;
      aw_idx     <= '0;
      aw_err     <= 1'b0;
      w_data     <= '0;
      w_strb     <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      for (int unsigned i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
    end else begin
      aw_full    <= aw_full_n;
      w_full     <= w_full_n;
      bvalid_q   <= bvalid_n;
      aw_ready_q <= !aw_full_n && !bvalid_n;
      w_ready_q  <= !w_full_n && !bvalid_n;
      if (aw_hs) begin
        aw_idx <= S_AXI_AWADDR[3:2];
        aw_err <= aw_oor;
      end
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        bresp_q <= aw_err ? RESP_SLVERR : RESP_OKAY;
        if (!aw_err) begin
          for (int unsigned n = 0; n < STRB_W; n++) begin
            if (w_strb[n]) regs[aw_idx][8*n +: 8] <= w_data[8*n +: 8];
          end
        end
      end
    end
  end

  // Read samples regs before any same-edge commit lands, returning the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      ar_ready_q <= !rvalid_q && !ar_hs;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= ar_oor ? '0 : regs[S_AXI_ARADDR[3:2]];
        rresp_q  <= ar_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    slv_regs = '0;
    for (int unsigned i = 0; i < C_NUM_REGS; i++)
      slv_regs[i*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = regs[i];
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = w_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_ad1_s00_axi_regs.sv
// Scoreboard bench for ad1_s00_axi_regs: directed scenarios plus random traffic
// checked against an array-based register model.
module tb_ad1_s00_axi_regs;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [5:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic         bready = 1'b1, rready = 1'b1;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] slv_regs;

  always #5 aclk = ~aclk;

  ad1_s00_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .C_NUM_REGS(4)
  ) dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .slv_regs(slv_regs)
  );

  int n_checks = 0, n_fail = 0;
  int b_seen = 0, r_seen = 0, b_issued = 0, r_issued = 0;
  logic [31:0] model_regs [4];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no completion within the cycle budget, expected completion", name);
  endtask

  function automatic logic [1:0] model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
`ifdef AD1_ADDR_DECODE_ERR_EN
    if (a[5:4] != 2'b00) return 2'b10;
`endif
    for (int n = 0; n < 4; n++)
      if (s[n]) model_regs[a[3:2]][8*n +: 8] = d[8*n +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [5:0] a);
`ifdef AD1_ADDR_DECODE_ERR_EN
    if (a[5:4] != 2'b00) return {2'b10, 32'h0};
`endif
    return {2'b00, model_regs[a[3:2]]};
  endfunction

  // Monitor: pops an expectation whenever a response handshake is about to complete.
  always @(negedge aclk) begin : monitor
    logic [33:0] e;
    if (aresetn) begin
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected: got BVALID=1 expected no write response");
        end else begin
          check("bresp", bresp, exp_b_q.pop_front());
        end
        b_seen++;
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL r_unexpected: got RVALID=1 expected no read response");
        end else begin
          e = exp_r_q.pop_front();
          check("rresp", rresp, e[33:32]);
          check("rdata", rdata, e[31:0]);
        end
        r_seen++;
      end
    end
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [5:0] a, input int dly);
    repeat (dly) tick();
    awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
    for (int t = 0; ; t++) begin
      if (awready) begin tick(); break; end
      if (t >= 50) begin timeout_fail("aw_handshake"); break; end
      tick();
    end
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    repeat (dly) tick();
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int t = 0; ; t++) begin
      if (wready) begin tick(); break; end
      if (t >= 50) begin timeout_fail("w_handshake"); break; end
      tick();
    end
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [5:0] a, input int dly);
    repeat (dly) tick();
    araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
    for (int t = 0; ; t++) begin
      if (arready) begin tick(); break; end
      if (t >= 50) begin timeout_fail("ar_handshake"); break; end
      tick();
    end
    arvalid = 1'b0;
  endtask

  task automatic wait_b;
    int t = 0;
    while (b_seen < b_issued && t < 100) begin tick(); t++; end
    if (b_seen < b_issued) begin timeout_fail("b_response"); b_seen = b_issued; end
  endtask

  task automatic wait_r;
    int t = 0;
    while (r_seen < r_issued && t < 100) begin tick(); t++; end
    if (r_seen < r_issued) begin timeout_fail("r_response"); r_seen = r_issued; end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd);
    exp_b_q.push_back(model_write(a, d, s));
    b_issued++;
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    wait_b();
  endtask

  task automatic axi_read(input logic [5:0] a, input int dly);
    exp_r_q.push_back(model_read(a));
    r_issued++;
    send_ar(a, dly);
    wait_r();
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_awready"}, awready, 1'b0);
    check({p, "_wready"}, wready, 1'b0);
    check({p, "_bvalid"}, bvalid, 1'b0);
    check({p, "_arready"}, arready, 1'b0);
    check({p, "_rvalid"}, rvalid, 1'b0);
    check({p, "_bresp"}, bresp, 2'b00);
    check({p, "_rresp"}, rresp, 2'b00);
    check({p, "_rdata"}, rdata, 32'h0);
    check({p, "_slv_regs"}, slv_regs, 128'h0);
  endtask

  // Split AW/W arrival: the second channel comes three cycles after the first.
  task automatic split_write(input bit aw_first);
    logic [1:0] e;
    e = model_write(6'h08, 32'hDEADBEEF, 4'hF);
    exp_b_q.push_back(e);
    b_issued++;
    if (aw_first) send_aw(6'h08, 0); else send_w(32'hDEADBEEF, 4'hF, 0);
    repeat (3) begin check("split_no_early_b", bvalid, 1'b0); tick(); end
    if (aw_first) send_w(32'hDEADBEEF, 4'hF, 0); else send_aw(6'h08, 0);
    check("split_b_at_hs_edge", bvalid, 1'b0);
    tick();
    check("split_b_latency", bvalid, 1'b1);
    wait_b();
    check("split_reg2", slv_regs[95:64], 32'hDEADBEEF);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [1:0]  e;
    logic [33:0] er;
    int t;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;

    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;
    check("arready_at_release", arready, 1'b0);
    tick();
    check("awready_after_release", awready, 1'b1);
    check("wready_after_release", wready, 1'b1);
    check("arready_after_release", arready, 1'b1);

    // Basic fill and readback.
    for (int i = 0; i < 4; i++) axi_write(6'(i*4), 32'(i+1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(6'(i*4), 0);
    check("fill_slv_regs", slv_regs, 128'h00000004_00000003_00000002_00000001);

    // Partial byte strobes.
    axi_write(6'h04, 32'hAABBCCDD, 4'hF, 0, 0);
    axi_write(6'h04, 32'h11223344, 4'b0101, 0, 0);
    axi_read(6'h04, 0);
    check("strobe_reg1", slv_regs[63:32], 32'hAA22CC44);

    split_write(1'b1);
    axi_write(6'h08, 32'h0, 4'hF, 0, 0);
    split_write(1'b0);

    // Write response backpressure.
    bready = 1'b0;
    exp_b_q.push_back(model_write(6'h0C, 32'hCAFEF00D, 4'hF));
    b_issued++;
    fork
      send_aw(6'h0C, 0);
      send_w(32'hCAFEF00D, 4'hF, 0);
    join
    t = 0;
    while (!bvalid && t < 10) begin tick(); t++; end
    if (!bvalid) timeout_fail("hold_b_rise");
    repeat (5) begin
      check("hold_bvalid", bvalid, 1'b1);
      check("hold_bresp", bresp, 2'b00);
      check("hold_awready", awready, 1'b0);
      check("hold_wready", wready, 1'b0);
      tick();
    end
    bready = 1'b1;
    wait_b();
    axi_write(6'h00, 32'h13579BDF, 4'hF, 0, 0);

    // Read response backpressure.
    rready = 1'b0;
    er = model_read(6'h0C);
    exp_r_q.push_back(er);
    r_issued++;
    send_ar(6'h0C, 0);
    repeat (5) begin
      check("hold_rvalid", rvalid, 1'b1);
      check("hold_rdata", rdata, er[31:0]);
      check("hold_arready", arready, 1'b0);
      tick();
    end
    rready = 1'b1;
    wait_r();

    // Reset with AW captured and W still pending.
    send_aw(6'h04, 0);
    wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    repeat (2) tick();
    aresetn = 1'b1;
    repeat (5) begin check("midreset_no_b", bvalid, 1'b0); tick(); end
    for (int i = 0; i < 4; i++) axi_read(6'(i*4), 0);

    // Upper address bits: decode error or alias onto reg1.
    axi_write(6'h04, 32'h00000077, 4'hF, 0, 0);
    axi_write(6'h14, 32'h0000005A, 4'hF, 0, 0);
    check("oor_reg1", slv_regs[63:32], model_regs[1]);
    axi_read(6'h14, 0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(6'($urandom_range(0, 15) * 4), $urandom, 4'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(6'($urandom_range(0, 15) * 4), $urandom_range(0, 2));
    end
    for (int i = 0; i < 4; i++)
      check("final_slv_regs", slv_regs[i*32 +: 32], model_regs[i]);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
